// File: rtl/pkt_mem_arbiter_if.sv
// Packet buffer arbiter bus bundle.
// Groups the writer handshake (wr_req/wr_addr/wr_data/wr_ack), the reader
// handshake (rd_req/rd_addr/rd_ack/rd_valid/rd_data), the single-port memory
// bus (mem_cs/mem_we/mem_addr/mem_wdata/mem_rdata) and the busy flag.
//   slave  : arbiter side (drives acks, read data and the memory bus)
//   master : requester/memory side (drives requests and mem_rdata)
interface pkt_mem_arbiter_if #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 8
);
   logic                  wr_req;
   logic [ADDR_W-1:0]     wr_addr;
   logic [DATA_W-1:0]     wr_data;
   logic                  wr_ack;
   logic                  rd_req;
   logic [ADDR_W-1:0]     rd_addr;
   logic                  rd_ack;
   logic                  rd_valid;
   logic [2*DATA_W-1:0]   rd_data;
   logic                  mem_cs;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W-1:0]     mem_rdata;
   logic                  busy;

   modport slave (
      input  wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rdata,
      output wr_ack, rd_ack, rd_valid, rd_data, mem_cs, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rdata,
      input  wr_ack, rd_ack, rd_valid, rd_data, mem_cs, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/pkt_mem_arbiter.sv
// Packet buffer arbiter.
// Shares a single-port byte memory between the RX writer (priority) and the
// display reader, which fetches atomic 2-byte words {mem[A], mem[A+1]}.
// A starvation counter lets the reader in after STARVE_MAX consecutive writer
// grants while it is waiting. All outputs are registered.
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active high
//   bus  : pkt_mem_arbiter_if.slave (requester handshakes, memory bus, busy)
module pkt_mem_arbiter #(
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   pkt_mem_arbiter_if.slave      bus
);

   localparam int unsigned SW = $clog2(STARVE_MAX + 2);
   localparam int unsigned LW = $clog2(MEM_LAT + 2);
   localparam logic [SW-1:0] StarveMaxC = SW'(STARVE_MAX);
   localparam logic [LW-1:0] HiCapC     = LW'(MEM_LAT);
   localparam logic [LW-1:0] LoCapC     = LW'(MEM_LAT + 1);

   typedef enum logic [2:0] {StIdle, StWrite, StRdHi, StRdLo, StRdWait} state_t;

   state_t              state;
   logic [SW-1:0]       starve_cnt;
   logic [LW-1:0]       lat_cnt;     // cycles since the high-byte issue cycle
   logic [DATA_W-1:0]   hi_byte;
   logic                rd_grant;

   assign rd_grant = bus.rd_req && (!bus.wr_req || (starve_cnt == StarveMaxC));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= StIdle;
         starve_cnt    <= '0;
         lat_cnt       <= '0;
         hi_byte       <= '0;
         bus.wr_ack    <= 1'b0;
         bus.rd_ack    <= 1'b0;
         bus.rd_valid  <= 1'b0;
         bus.rd_data   <= '0;
         bus.mem_cs    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.busy      <= 1'b0;
      end else begin
         bus.wr_ack   <= 1'b0;
         bus.rd_ack   <= 1'b0;
         bus.rd_valid <= 1'b0;
         bus.mem_we   <= 1'b0;
         if (!bus.rd_req) starve_cnt <= '0;

         unique case (state)
            StIdle: begin
               bus.mem_cs <= 1'b0;
               if (rd_grant) begin
                  state        <= StRdHi;
                  bus.busy     <= 1'b1;
                  bus.mem_cs   <= 1'b1;
                  bus.mem_addr <= bus.rd_addr;  // mem_addr doubles as the latched A
                  bus.rd_ack   <= 1'b1;
                  starve_cnt   <= '0;
                  lat_cnt      <= '0;
               end else if (bus.wr_req) begin
                  state         <= StWrite;
                  bus.busy      <= 1'b1;
                  bus.mem_cs    <= 1'b1;
                  bus.mem_we    <= 1'b1;
                  bus.mem_addr  <= bus.wr_addr;
                  bus.mem_wdata <= bus.wr_data;
                  bus.wr_ack    <= 1'b1;
                  if (bus.rd_req && (starve_cnt != StarveMaxC)) begin
                     starve_cnt <= starve_cnt + SW'(1);
                  end
               end
            end

            // Always return to idle so a held wr_req cannot be re-granted back to back.
            StWrite: begin
               state      <= StIdle;
               bus.busy   <= 1'b0;
               bus.mem_cs <= 1'b0;
            end

            StRdHi, StRdLo, StRdWait: begin
               lat_cnt <= lat_cnt + LW'(1);
               if (lat_cnt == HiCapC) hi_byte <= bus.mem_rdata;
               if (lat_cnt == LoCapC) begin
                  bus.rd_data  <= {hi_byte, bus.mem_rdata};
                  bus.rd_valid <= 1'b1;
                  bus.busy     <= 1'b0;
                  state        <= StIdle;
               end else if (state == StRdHi) begin
                  state        <= StRdLo;
                  bus.mem_addr <= bus.mem_addr + ADDR_W'(1);  // wraps at the top
               end else if (state == StRdLo) begin
                  state      <= StRdWait;
                  bus.mem_cs <= 1'b0;
               end
            end

            default: begin
               state    <= StIdle;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pkt_mem_arbiter.sv
module tb_pkt_mem_arbiter;

   logic clk;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;

   pkt_mem_arbiter_if #(.ADDR_W(10), .DATA_W(8)) bus1 ();
   pkt_mem_arbiter_if #(.ADDR_W(10), .DATA_W(8)) bus3 ();

   pkt_mem_arbiter #(.ADDR_W(10), .DATA_W(8), .MEM_LAT(1), .STARVE_MAX(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   pkt_mem_arbiter #(.ADDR_W(10), .DATA_W(8), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory models: latency 1 and latency 3. 8'hEE marks "no read issued".
   logic [7:0] mem1 [1024];
   logic [7:0] mem3 [1024];
   logic [7:0] pipe1;
   logic [7:0] pipe3 [3];

   always @(posedge clk) begin
      if (bus1.mem_cs && bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_wdata;
      pipe1 <= (bus1.mem_cs && !bus1.mem_we) ? mem1[bus1.mem_addr] : 8'hEE;
      if (bus3.mem_cs && bus3.mem_we) mem3[bus3.mem_addr] <= bus3.mem_wdata;
      pipe3[0] <= (bus3.mem_cs && !bus3.mem_we) ? mem3[bus3.mem_addr] : 8'hEE;
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end

   assign bus1.mem_rdata = pipe1;
   assign bus3.mem_rdata = pipe3[2];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero1(input string tag);
      check({tag, "_cs"},    32'(bus1.mem_cs), 0);
      check({tag, "_we"},    32'(bus1.mem_we), 0);
      check({tag, "_addr"},  32'(bus1.mem_addr), 0);
      check({tag, "_wdata"}, 32'(bus1.mem_wdata), 0);
      check({tag, "_wrack"}, 32'(bus1.wr_ack), 0);
      check({tag, "_rdack"}, 32'(bus1.rd_ack), 0);
      check({tag, "_rdval"}, 32'(bus1.rd_valid), 0);
      check({tag, "_rddat"}, 32'(bus1.rd_data), 0);
      check({tag, "_busy"},  32'(bus1.busy), 0);
   endtask

   task automatic wr1(input logic [9:0] a, input logic [7:0] d);
      bus1.wr_req  = 1'b1;
      bus1.wr_addr = a;
      bus1.wr_data = d;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus1.wr_ack) break;
      end
      check("wr1_ack", 32'(bus1.wr_ack), 1);
      bus1.wr_req = 1'b0;
      step();
   endtask

   task automatic wr3(input logic [9:0] a, input logic [7:0] d);
      bus3.wr_req  = 1'b1;
      bus3.wr_addr = a;
      bus3.wr_data = d;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus3.wr_ack) break;
      end
      check("wr3_ack", 32'(bus3.wr_ack), 1);
      bus3.wr_req = 1'b0;
      step();
   endtask

   int  acks;
   int  stray;
   int  nval;
   bit  got;

   initial begin
      rst = 1'b1;
      bus1.wr_req = 1'b0; bus1.wr_addr = '0; bus1.wr_data = '0;
      bus1.rd_req = 1'b0; bus1.rd_addr = '0;
      bus3.wr_req = 1'b0; bus3.wr_addr = '0; bus3.wr_data = '0;
      bus3.rd_req = 1'b0; bus3.rd_addr = '0;

      // Reset state
      step();
      step();
      check_zero1("reset");
      check("reset_busy3", 32'(bus3.busy), 0);
      rst = 1'b0;
      step();
      step();

      // Test 1: single write
      bus1.wr_req = 1'b1; bus1.wr_addr = 10'h005; bus1.wr_data = 8'hA5;
      check("t1_n_ack", 32'(bus1.wr_ack), 0);
      step();
      check("t1_cs",    32'(bus1.mem_cs), 1);
      check("t1_we",    32'(bus1.mem_we), 1);
      check("t1_addr",  32'(bus1.mem_addr), 'h005);
      check("t1_wdata", 32'(bus1.mem_wdata), 'hA5);
      check("t1_ack",   32'(bus1.wr_ack), 1);
      check("t1_busy",  32'(bus1.busy), 1);
      bus1.wr_req = 1'b0;
      step();
      check("t1_ack_off",  32'(bus1.wr_ack), 0);
      check("t1_we_off",   32'(bus1.mem_we), 0);
      check("t1_busy_off", 32'(bus1.busy), 0);
      check("t1_wdata_hold", 32'(bus1.mem_wdata), 'hA5);

      wr1(10'h006, 8'h3C);
      wr1(10'h3FF, 8'h11);
      wr1(10'h000, 8'h22);

      // Test 2: read 0x005
      bus1.rd_req = 1'b1; bus1.rd_addr = 10'h005;
      step();
      check("t2_addr_hi", 32'(bus1.mem_addr), 'h005);
      check("t2_rdack",   32'(bus1.rd_ack), 1);
      check("t2_cs_hi",   32'(bus1.mem_cs), 1);
      check("t2_we_hi",   32'(bus1.mem_we), 0);
      bus1.rd_req = 1'b0;
      step();
      check("t2_addr_lo",  32'(bus1.mem_addr), 'h006);
      check("t2_rdack_off", 32'(bus1.rd_ack), 0);
      check("t2_val_n2",   32'(bus1.rd_valid), 0);
      step();
      check("t2_val_n3",   32'(bus1.rd_valid), 0);
      check("t2_cs_wait",  32'(bus1.mem_cs), 0);
      check("t2_addr_hold", 32'(bus1.mem_addr), 'h006);
      step();
      check("t2_val_n4",   32'(bus1.rd_valid), 1);
      check("t2_data",     32'(bus1.rd_data), 'hA53C);
      check("t2_busy_n4",  32'(bus1.busy), 0);
      step();
      check("t2_val_n5",   32'(bus1.rd_valid), 0);
      check("t2_data_hold", 32'(bus1.rd_data), 'hA53C);

      // Test 3: address wrap
      bus1.rd_req = 1'b1; bus1.rd_addr = 10'h3FF;
      step();
      check("t3_addr_hi", 32'(bus1.mem_addr), 'h3FF);
      bus1.rd_req = 1'b0;
      step();
      check("t3_addr_wrap", 32'(bus1.mem_addr), 'h000);
      step();
      step();
      check("t3_val",  32'(bus1.rd_valid), 1);
      check("t3_data", 32'(bus1.rd_data), 'h1122);
      step();

      // Test 4: starvation guard
      bus1.wr_req = 1'b1; bus1.wr_addr = 10'h010; bus1.wr_data = 8'h55;
      step();
      check("t4_first_ack", 32'(bus1.wr_ack), 1);
      bus1.rd_req = 1'b1; bus1.rd_addr = 10'h005;
      acks = 0;
      got  = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         step();
         if (bus1.wr_ack) acks++;
         if (bus1.rd_ack) got = 1'b1;
      end
      check("t4_rdack_seen", 32'(got), 1);
      check("t4_wr_acks",    32'(acks), 4);
      check("t4_starve_clr", 32'(dut.starve_cnt), 0);
      bus1.rd_req = 1'b0;
      stray = 0;
      got   = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         step();
         if (bus1.wr_ack) stray++;
         if (bus1.rd_valid) got = 1'b1;
      end
      check("t4_rdval_seen", 32'(got), 1);
      check("t4_no_wr_in_rd", 32'(stray), 0);
      check("t4_data", 32'(bus1.rd_data), 'hA53C);
      step();
      check("t4_resume", 32'(bus1.wr_ack), 1);
      bus1.wr_req = 1'b0;
      step();
      step();

      // Test 5: reset during RD_LO
      bus1.rd_req = 1'b1; bus1.rd_addr = 10'h005;
      step();
      bus1.rd_req = 1'b0;
      step();
      check("t5_in_rdlo", 32'(bus1.mem_addr), 'h006);
      rst = 1'b1;
      #1;
      check_zero1("t5_async");
      step();
      rst = 1'b0;
      nval = 0;
      stray = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus1.rd_valid) nval++;
         if (bus1.rd_ack || bus1.wr_ack) stray++;
      end
      check("t5_no_rdval", 32'(nval), 0);
      check("t5_no_acks",  32'(stray), 0);
      check("t5_rddata",   32'(bus1.rd_data), 0);
      check("t5_busy",     32'(bus1.busy), 0);

      // Test 6: MEM_LAT=3 instance
      wr3(10'h005, 8'hA5);
      wr3(10'h006, 8'h3C);
      bus3.rd_req = 1'b1; bus3.rd_addr = 10'h005;
      step();
      check("t6_rdack", 32'(bus3.rd_ack), 1);
      check("t6_addr_hi", 32'(bus3.mem_addr), 'h005);
      bus3.rd_req = 1'b0;
      step();
      check("t6_addr_lo", 32'(bus3.mem_addr), 'h006);
      bus3.wr_req = 1'b1; bus3.wr_addr = 10'h020; bus3.wr_data = 8'h77;
      nval = 0;
      stray = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (bus3.rd_valid) nval++;
         if (bus3.wr_ack) stray++;
      end
      check("t6_early_val", 32'(nval), 0);
      check("t6_early_wr",  32'(stray), 0);
      step();
      check("t6_val_n6",  32'(bus3.rd_valid), 1);
      check("t6_data",    32'(bus3.rd_data), 'hA53C);
      check("t6_wr_n6",   32'(bus3.wr_ack), 0);
      step();
      check("t6_wr_n7",   32'(bus3.wr_ack), 1);
      check("t6_waddr",   32'(bus3.mem_addr), 'h020);
      check("t6_wdata",   32'(bus3.mem_wdata), 'h77);
      bus3.wr_req = 1'b0;
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
